// File: rtl/mask_centroid.sv
// Binary-mask centroid: accumulates mask pixel count and coordinate sums per frame,
// then divides the sums by the count with a serial restoring divider after each frame end.
//
// state    | meaning
// IDLE     | waiting for frame end; snapshot taken on entry to DIV_X
// DIV_X    | 31 restoring-division steps of sum_x / count
// DIV_Y    | 31 restoring-division steps of sum_y / count
// DONE     | results on the outputs, centroid_valid high
module mask_centroid #(
    parameter logic [9:0] H_SIZE = 10'd83,
    parameter logic [9:0] V_SIZE = 10'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        mask,
    input  logic        in_de,
    input  logic        in_vsync,
    input  logic        in_hsync,
    output logic        out_mask,
    output logic        out_de,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic [9:0]  x_center,
    output logic [9:0]  y_center,
    output logic [20:0] pix_count,
    output logic        centroid_valid,
    output logic        empty,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIV_X = 2'd1;
    localparam logic [1:0] ST_DIV_Y = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [4:0] STEP_LAST = 5'd30;

    logic        out_mask_q, out_mask_d;
    logic        out_de_q, out_de_d;
    logic        out_vsync_q, out_vsync_d;
    logic        out_hsync_q, out_hsync_d;
    logic        de_prev_q, de_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic [9:0]  xc_q, xc_d;
    logic [9:0]  yc_q, yc_d;
    logic [20:0] cnt_q, cnt_d;
    logic [30:0] sx_q, sx_d;
    logic [30:0] sy_q, sy_d;
    logic [20:0] snap_cnt_q, snap_cnt_d;
    logic [30:0] snap_sy_q, snap_sy_d;
    logic [1:0]  state_q, state_d;
    logic [4:0]  step_q, step_d;
    logic [20:0] rem_q, rem_d;
    logic [30:0] quo_q, quo_d;
    logic [9:0]  qx_q, qx_d;
    logic [9:0]  x_center_q, x_center_d;
    logic [9:0]  y_center_q, y_center_d;
    logic [20:0] pix_count_q, pix_count_d;
    logic        empty_q, empty_d;
    logic        valid_q, valid_d;

    logic        de_fall;
    logic        frame_end;
    logic        pix_hit;
    logic        snap_zero;
    logic [9:0]  xc_inc;
    logic [9:0]  yc_inc;
    logic [21:0] rem_shift;
    logic        rem_ge;
    logic [20:0] rem_sub;
    logic [20:0] rem_next;
    logic [30:0] quo_next;

    assign de_fall   = de_prev_q & ~in_de;
    assign frame_end = in_vsync & ~vs_prev_q;
    assign pix_hit   = in_de & mask & ~in_vsync;
    assign snap_zero = (snap_cnt_q == 21'd0);
    assign xc_inc    = (xc_q >= H_SIZE - 10'd1) ? xc_q : xc_q + 10'd1;
    assign yc_inc    = (yc_q >= V_SIZE - 10'd1) ? yc_q : yc_q + 10'd1;

    // One restoring step: the partial remainder always stays below the divisor,
    // so the 21-bit modular subtraction is exact whenever it is taken.
    assign rem_shift = {rem_q, quo_q[30]};
    assign rem_ge    = (rem_shift >= {1'b0, snap_cnt_q});
    assign rem_sub   = rem_shift[20:0] - snap_cnt_q;
    assign rem_next  = rem_ge ? rem_sub : rem_shift[20:0];
    assign quo_next  = {quo_q[29:0], rem_ge};

    always_comb begin
        out_mask_d  = out_mask_q;
        out_de_d    = out_de_q;
        out_vsync_d = out_vsync_q;
        out_hsync_d = out_hsync_q;
        de_prev_d   = de_prev_q;
        vs_prev_d   = vs_prev_q;
        xc_d        = xc_q;
        yc_d        = yc_q;
        cnt_d       = cnt_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        snap_cnt_d  = snap_cnt_q;
        snap_sy_d   = snap_sy_q;
        state_d     = state_q;
        step_d      = step_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        qx_d        = qx_q;
        x_center_d  = x_center_q;
        y_center_d  = y_center_q;
        pix_count_d = pix_count_q;
        empty_d     = empty_q;
        valid_d     = valid_q;

        if (ce) begin
            out_mask_d  = mask & in_de;
            out_de_d    = in_de;
            out_vsync_d = in_vsync;
            out_hsync_d = in_hsync;
            de_prev_d   = in_de;
            vs_prev_d   = in_vsync;

            if (de_fall) begin
                xc_d = 10'd0;
            end else if (in_de) begin
                xc_d = xc_inc;
            end

            // Frame end wins over a coincident line end: the row clears.
            if (frame_end) begin
                yc_d = 10'd0;
            end else if (de_fall) begin
                yc_d = yc_inc;
            end

            if (frame_end) begin
                cnt_d = 21'd0;
                sx_d  = 31'd0;
                sy_d  = 31'd0;
            end else if (pix_hit) begin
                cnt_d = cnt_q + 21'd1;
                sx_d  = sx_q + {21'd0, xc_q};
                sy_d  = sy_q + {21'd0, yc_q};
            end

            valid_d = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (frame_end) begin
                        snap_cnt_d = cnt_q;
                        snap_sy_d  = sy_q;
                        quo_d      = sx_q;
                        rem_d      = 21'd0;
                        step_d     = STEP_LAST;
                        state_d    = ST_DIV_X;
                    end
                end
                ST_DIV_X: begin
                    rem_d  = rem_next;
                    quo_d  = quo_next;
                    step_d = step_q - 5'd1;
                    if (step_q == 5'd0) begin
                        qx_d    = quo_next[9:0];
                        quo_d   = snap_sy_q;
                        rem_d   = 21'd0;
                        step_d  = STEP_LAST;
                        state_d = ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    rem_d  = rem_next;
                    quo_d  = quo_next;
                    step_d = step_q - 5'd1;
                    if (step_q == 5'd0) begin
                        // Load results now so they are visible during DONE.
                        x_center_d  = snap_zero ? 10'd0 : qx_q;
                        y_center_d  = snap_zero ? 10'd0 : quo_next[9:0];
                        pix_count_d = snap_cnt_q;
                        empty_d     = snap_zero;
                        valid_d     = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_mask_q  <= 1'b0;
            out_de_q    <= 1'b0;
            out_vsync_q <= 1'b0;
            out_hsync_q <= 1'b0;
            de_prev_q   <= 1'b0;
            // Treated as already high so a vsync level present at reset release is not a frame end.
            vs_prev_q   <= 1'b1;
            xc_q        <= 10'd0;
            yc_q        <= 10'd0;
            cnt_q       <= 21'd0;
            sx_q        <= 31'd0;
            sy_q        <= 31'd0;
            snap_cnt_q  <= 21'd0;
            snap_sy_q   <= 31'd0;
            state_q     <= ST_IDLE;
            step_q      <= 5'd0;
            rem_q       <= 21'd0;
            quo_q       <= 31'd0;
            qx_q        <= 10'd0;
            x_center_q  <= 10'd0;
            y_center_q  <= 10'd0;
            pix_count_q <= 21'd0;
            empty_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            out_mask_q  <= out_mask_d;
            out_de_q    <= out_de_d;
            out_vsync_q <= out_vsync_d;
            out_hsync_q <= out_hsync_d;
            de_prev_q   <= de_prev_d;
            vs_prev_q   <= vs_prev_d;
            xc_q        <= xc_d;
            yc_q        <= yc_d;
            cnt_q       <= cnt_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            snap_cnt_q  <= snap_cnt_d;
            snap_sy_q   <= snap_sy_d;
            state_q     <= state_d;
            step_q      <= step_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            qx_q        <= qx_d;
            x_center_q  <= x_center_d;
            y_center_q  <= y_center_d;
            pix_count_q <= pix_count_d;
            empty_q     <= empty_d;
            valid_q     <= valid_d;
        end
    end

    assign out_mask       = out_mask_q;
    assign out_de         = out_de_q;
    assign out_vsync      = out_vsync_q;
    assign out_hsync      = out_hsync_q;
    assign x_center       = x_center_q;
    assign y_center       = y_center_q;
    assign pix_count      = pix_count_q;
    assign empty          = empty_q;
    assign centroid_valid = valid_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mask_centroid.sv
// Self-checking bench for mask_centroid: directed frame table, reset and ce-stall
// sequences, and random frames checked against an arithmetic centroid model.
module tb_mask_centroid;

    localparam int H = 83;
    localparam int V = 64;
    localparam int HBLANK = 3;

    logic        clk = 1'b0;
    logic        rst, ce, mask, in_de, in_vsync, in_hsync;
    logic        out_mask, out_de, out_vsync, out_hsync;
    logic [9:0]  x_center, y_center;
    logic [20:0] pix_count;
    logic        centroid_valid, empty, busy;

    int n_vec = 0;
    int n_err = 0;
    bit dither = 1'b0;
    bit m [0:69][0:99];

    mask_centroid dut (
        .clk(clk), .rst(rst), .ce(ce), .mask(mask),
        .in_de(in_de), .in_vsync(in_vsync), .in_hsync(in_hsync),
        .out_mask(out_mask), .out_de(out_de), .out_vsync(out_vsync), .out_hsync(out_hsync),
        .x_center(x_center), .y_center(y_center), .pix_count(pix_count),
        .centroid_valid(centroid_valid), .empty(empty), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int x0, x1, y0, y1;
        int len, nl;
        int ex, ey, ec;
        bit ee;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mask();
        for (int y = 0; y < 70; y++)
            for (int x = 0; x < 100; x++)
                m[y][x] = 1'b0;
    endtask

    task automatic fill_rect(input int x0, input int x1, input int y0, input int y1);
        clear_mask();
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                m[y][x] = 1'b1;
    endtask

    // Reference: centroid of the mask, coordinates clipped to the active area.
    task automatic model(input int len, input int nl,
                         output int ex, output int ey, output int ec, output bit ee);
        longint sx = 0, sy = 0;
        int c = 0;
        for (int y = 0; y < nl; y++)
            for (int x = 0; x < len; x++)
                if (m[y][x]) begin
                    c++;
                    sx += (x > H - 1) ? H - 1 : x;
                    sy += (y > V - 1) ? V - 1 : y;
                end
        ec = c;
        ee = (c == 0);
        ex = (c == 0) ? 0 : int'(sx / c);
        ey = (c == 0) ? 0 : int'(sy / c);
    endtask

    // Advance one accepted (ce-high) cycle, optionally with random ce gaps.
    task automatic tick();
        bit took = 1'b0;
        while (!took) begin
            ce = dither ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk);
            took = ce;
            #1;
            if (took) begin
                chk("out_mask", out_mask, mask & in_de);
                chk("out_de", out_de, in_de);
                chk("out_hsync", out_hsync, in_hsync);
                chk("out_vsync", out_vsync, in_vsync);
            end
        end
    endtask

    task automatic send_lines(input int len, input int nl);
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < len; x++) begin
                in_de = 1'b1; in_hsync = 1'b0; mask = m[y][x];
                tick();
            end
            for (int i = 0; i < HBLANK; i++) begin
                in_de = 1'b0; in_hsync = (i == 1); mask = 1'($urandom);
                tick();
            end
        end
        mask = 1'b0; in_hsync = 1'b0;
    endtask

    task automatic frame_check(input int len, input int nl,
                               input int ex, input int ey, input int ec, input bit ee);
        int lat = 0;
        bit got = 1'b0;
        send_lines(len, nl);
        dither = 1'b0; ce = 1'b1;
        in_vsync = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_E", busy, 1);
        while (!got && lat < 100) begin
            if (centroid_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
                if (lat == 3) in_vsync = 1'b0;
            end
        end
        in_vsync = 1'b0;
        chk("valid_seen", got, 1);
        chk("valid_latency", lat, 62);
        chk("x_center", x_center, ex);
        chk("y_center", y_center, ey);
        chk("pix_count", pix_count, ec);
        chk("empty", empty, ee);
        chk("busy_done", busy, 1);
        @(posedge clk); #1;
        chk("valid_width", centroid_valid, 0);
        chk("busy_idle", busy, 0);
        chk("x_hold", x_center, ex);
        chk("cnt_hold", pix_count, ec);
    endtask

    task automatic random_frame(input int pct);
        int ex, ey, ec;
        bit ee;
        clear_mask();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                m[y][x] = ($urandom_range(0, 99) < pct);
        model(H, V, ex, ey, ec, ee);
        frame_check(H, V, ex, ey, ec, ee);
    endtask

    initial begin
        tbl[0] = '{"single",   5,  5,  3,  3, 83,  8,  5,  3,    1, 1'b0};
        tbl[1] = '{"empty",    1,  0,  0,  0, 83,  4,  0,  0,    0, 1'b1};
        tbl[2] = '{"block2x2",10, 11, 20, 21, 83, 24, 10, 20,    4, 1'b0};
        tbl[3] = '{"full",     0, 82,  0, 63, 83, 64, 41, 31, 5312, 1'b0};
        tbl[4] = '{"corner",  82, 82, 63, 63, 83, 64, 82, 63,    1, 1'b0};
        tbl[5] = '{"xsat",    88, 88,  2,  2, 90,  4, 82,  2,    1, 1'b0};
        tbl[6] = '{"ysat",     0,  0, 66, 66, 83, 67,  0, 63,    1, 1'b0};

        rst = 1'b1; ce = 1'b1; mask = 1'b0; in_de = 1'b0; in_vsync = 1'b0; in_hsync = 1'b0;
        #23;
        chk("rst_x", x_center, 0);
        chk("rst_y", y_center, 0);
        chk("rst_cnt", pix_count, 0);
        chk("rst_valid", centroid_valid, 0);
        chk("rst_empty", empty, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_de", out_de, 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        for (int i = 0; i < 7; i++) begin
            $display("vector %s", tbl[i].name);
            fill_rect(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1);
            frame_check(tbl[i].len, tbl[i].nl, tbl[i].ex, tbl[i].ey, tbl[i].ec, tbl[i].ee);
        end

        // Reset 20 cycles into the division: no result, outputs cleared.
        begin
            bit seen = 1'b0;
            fill_rect(5, 5, 3, 3);
            send_lines(H, 8);
            ce = 1'b1; in_vsync = 1'b1;
            @(posedge clk);
            for (int i = 0; i < 3; i++) @(posedge clk);
            in_vsync = 1'b0;
            for (int i = 0; i < 16; i++) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("mid_rst_x", x_center, 0);
            chk("mid_rst_y", y_center, 0);
            chk("mid_rst_busy", busy, 0);
            @(negedge clk); rst = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                if (centroid_valid) seen = 1'b1;
            end
            chk("no_valid_after_rst", seen, 0);
            chk("post_rst_cnt", pix_count, 0);
        end
        random_frame(30);

        // ce held low for 10 cycles inside DIV_Y: pulse slips by 10, pass-through frozen.
        begin
            int clk_n = 0;
            bit got = 1'b0;
            logic od, om, oh;
            fill_rect(10, 11, 20, 21);
            send_lines(H, 24);
            ce = 1'b1; in_vsync = 1'b1;
            @(posedge clk); #1;
            while (clk_n < 40) begin
                @(posedge clk); #1;
                clk_n++;
                if (clk_n == 3) in_vsync = 1'b0;
            end
            od = out_de; om = out_mask; oh = out_hsync;
            ce = 1'b0; in_de = 1'b1; mask = 1'b1; in_hsync = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                clk_n++;
                chk("stall_out_de", out_de, od);
                chk("stall_out_mask", out_mask, om);
                chk("stall_out_hsync", out_hsync, oh);
                chk("stall_valid", centroid_valid, 0);
            end
            in_de = 1'b0; mask = 1'b0; in_hsync = 1'b0; ce = 1'b1;
            while (!got && clk_n < 150) begin
                if (centroid_valid) got = 1'b1;
                else begin
                    @(posedge clk); #1;
                    clk_n++;
                end
            end
            chk("stall_valid_seen", got, 1);
            chk("stall_latency", clk_n, 72);
            chk("stall_x", x_center, 10);
            chk("stall_y", y_center, 20);
            chk("stall_cnt", pix_count, 4);
            @(posedge clk); #1;
        end

        dither = 1'b1;
        random_frame(5);
        dither = 1'b1;
        random_frame(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
